seven_segment_scan_controller: RTL and testbench
================================================

# seven_segment_scan_controller

Drives a multiplexed common-anode/common-cathode seven-segment display from a per-digit segment frame. It sequences the `abcdefgh` / `digit` outputs one digit per time slot, inserting a blanking gap between digits to suppress ghosting. It applies PWM brightness and double-buffers the frame so that updates never tear mid-scan. It sits between `lab_top`'s display logic and the board-level inversion of `ABCDEFGH` / `DIGIT_N`.

## Interface
- `clk_mhz`, 50, system clock frequency; documentation only.
- `w_digit`, 6, number of digits scanned.
- `slot_cycles`, 50000, clock cycles per digit slot (1 ms at 50 MHz); must exceed `blank_cycles` + 1.
- `blank_cycles`, 500, cycles at the start of each slot with all outputs dark.
- `w_bright`, 4, brightness field width.

- `clk`, in, 1, system clock; all logic is on the rising edge.
- `rst`, in, 1, synchronous, active-low reset.
- `load`, in, 1, request to capture `frame`; accepted only when `ready`=1.
- `frame`, in, 8·`w_digit`, segment bits `abcdefgh` per digit; digit *i* is at [8i+7:8i].
- `enable_mask`, in, `w_digit`, bit *i*=1 means digit *i* is scanned.
- `brightness`, in, `w_bright`, PWM duty; 0 is dark, all-ones is fully on.
- `ready`, out, 1, high when no frame is pending commit.
- `abcdefgh`, out, 8, active-high segments for the current digit.
- `digit`, out, `w_digit`, one-hot active-high digit select; zero when dark.
- `frame_done`, out, 1, one-cycle pulse at each frame boundary.

## Operation
- Storage: a shadow register and an active register, each 8·`w_digit` bits. Both are zeroed by reset.
- Load handshake:
  - `load`=1 with `ready`=1 copies `frame` into the shadow register and sets `pending`, so `ready`=0 from the next cycle.
  - `load` while `ready`=0 is ignored; the shadow register is unchanged.
- Slot counter runs 0..`slot_cycles`−1, then wraps.
- State machine:
  - BLANK: slot counter < `blank_cycles`. `digit`=0 and `abcdefgh`=0.
  - ON: the rest of the slot.
  - BLANK → ON at counter = `blank_cycles`. ON → BLANK at wrap.
- Digit selection: at each slot wrap, the index advances to the next set bit of `enable_mask` above the current index, wrapping to the lowest set bit. `enable_mask` is sampled only at the wrap.
- Frame boundary: any wrap where the new index ≤ the old index, including the case of a single enabled digit. At a boundary:
  - if `pending`=1, the shadow register is copied to the active register and `pending` is cleared;
  - `frame_done` pulses.
- All-zero mask: the index stays put, the outputs stay dark in both states, and every wrap counts as a frame boundary, so commits still occur.
- PWM: a free-running `w_bright`-bit counter runs during ON.
  - Output on when count < `brightness`; when `brightness` is all-ones, output is always on.
  - `brightness` is sampled every cycle.
  - When on: `digit` = one-hot(index) and `abcdefgh` = active[index].
  - When off: both outputs are 0.
- Reset mid-scan: the block returns to the post-reset state on the next edge and any pending frame is discarded.

## Timing
- Reset values: `abcdefgh`=0, `digit`=0, `ready`=1, `frame_done`=0, index=0, slot counter=0, PWM counter=0, `pending`=0.
- The first slot after reset serves digit 0. The first cycle with `rst`=1 is slot cycle 0.
- All outputs are registered. An input change affects the outputs one cycle later.
- `load` accepted at edge *t*:
  - shadow register valid and `ready`=0 at *t*+1.
  - At the boundary edge *b*, the active register is updated, and `ready`=1 and `frame_done`=1 at *b*+1.
  - `frame_done`=0 at *b*+2.
- New data first appears in the ON phase of the slot that starts at *b*+1. There is no visible change before then (no tearing).
- ON phase length is `slot_cycles` − `blank_cycles`. There are at least `blank_cycles` dark cycles between any two different digits.
- `load` on the same edge as a boundary while `ready`=1: the shadow register is captured, and the commit waits for the next boundary.

## Test plan
Bench parameters: `w_digit`=4, `slot_cycles`=20, `blank_cycles`=4, `w_bright`=2.

- **Reset:** hold `rst`=0 for 3 cycles.
  - → `digit`=0, `abcdefgh`=0, `ready`=1, `frame_done`=0.
  - After release: cycles 0–3 dark, cycle 4 is the first ON cycle of digit 0.
- **Full scan:** `enable_mask`=4'b1111, `brightness`=3, load `frame`=32'h8040_2010.
  - → after the next boundary, `digit` runs 0001/0010/0100/1000 with `abcdefgh` 10/20/40/80, each for 16 ON cycles separated by 4 dark cycles.
  - `frame_done` pulses every 80 cycles.
- **Skip and wrap:** `enable_mask`=4'b1010.
  - → only `digit` 0010 and 1000 alternate.
  - The boundary is at the wrap 3→1. With a single bit (4'b0100), every wrap pulses `frame_done`.
- **No tearing:** load frame A, then load frame B while `ready`=0.
  - → B is ignored.
  - Display switches from A only at the boundary. `ready` returns to 1 on the same cycle `frame_done` pulses.
- **Brightness:** `brightness`=1.
  - → `digit` is nonzero on exactly 1 of every 4 ON cycles.
  - `brightness`=0 → always dark.
  - `brightness`=3 → all 16 ON cycles lit.
- **Mask zero and mid-scan reset:**
  - `enable_mask`=0 with a frame pending → outputs stay dark and the commit happens at the next wrap.
  - Assert `rst`=0 during an ON phase of digit 2 → next cycle all outputs are at reset values and the pending frame is lost.

Source files
------------

// File: rtl/seven_segment_scan_controller_if.sv
// Display-side bundle for the seven-segment scan controller:
// frame load handshake, scan controls and the registered drive outputs.
interface seven_segment_scan_controller_if #(
  parameter int w_digit  = 6,
  parameter int w_bright = 4
);
  logic                   load;
  logic [8*w_digit-1:0]   frame;
  logic [w_digit-1:0]     enable_mask;
  logic [w_bright-1:0]    brightness;
  logic                   ready;
  logic [7:0]             abcdefgh;
  logic [w_digit-1:0]     digit;
  logic                   frame_done;

  modport master (
    output load,
    output frame,
    output enable_mask,
    output brightness,
    input  ready,
    input  abcdefgh,
    input  digit,
    input  frame_done
  );

  modport slave (
    input  load,
    input  frame,
    input  enable_mask,
    input  brightness,
    output ready,
    output abcdefgh,
    output digit,
    output frame_done
  );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed seven-segment scanner: blanked digit slots, PWM dimming,
// and a shadow/active frame pair committed only at frame boundaries.
module seven_segment_scan_controller #(
  parameter int clk_mhz      = 50,
  parameter int w_digit      = 6,
  parameter int slot_cycles  = 50000,
  parameter int blank_cycles = 500,
  parameter int w_bright     = 4
) (
  input logic clk,
  input logic rst,
  seven_segment_scan_controller_if.slave bus
);

  localparam int w_idx = (w_digit > 1) ? $clog2(w_digit) : 1;
  localparam int w_cnt = $clog2(slot_cycles);

  typedef logic [w_idx-1:0]     idx_t;
  typedef logic [w_cnt-1:0]     cnt_t;
  typedef logic [w_bright-1:0]  pwm_t;
  typedef logic [w_digit-1:0]   dig_t;
  typedef logic [8*w_digit-1:0] frm_t;

  typedef enum logic {
    ST_BLANK,
    ST_ON
  } state_t;

  localparam cnt_t last_cnt  = cnt_t'(slot_cycles - 1);
  localparam cnt_t blank_cnt = cnt_t'(blank_cycles);

  if (clk_mhz < 1 || slot_cycles <= blank_cycles + 1) begin : g_bad_params
    $error("seven_segment_scan_controller: bad timing parameters");
  end

  state_t state, state_n;
  cnt_t   cnt, cnt_n;
  idx_t   idx, idx_n;
  logic   valid, valid_n;
  pwm_t   pwm, pwm_n;
  logic   pending, pending_n;
  frm_t   shadow, shadow_n;
  frm_t   active, active_n;

  logic [7:0] seg_q, seg_n;
  dig_t       dig_q, dig_n;
  logic       ready_q;
  logic       done_q;

  logic wrap;
  logic boundary;
  logic commit;
  logic take;
  logic lit;

  logic hi_found;
  logic lo_found;
  idx_t hi_idx;
  idx_t lo_idx;
  idx_t pick;

  // Next enabled digit above idx, else the lowest enabled one.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = idx;
    lo_idx   = idx;
    for (int i = w_digit - 1; i >= 0; i--) begin
      if (bus.enable_mask[i]) begin
        lo_found = 1'b1;
        lo_idx   = idx_t'(i);
        if (idx_t'(i) > idx) begin
          hi_found = 1'b1;
          hi_idx   = idx_t'(i);
        end
      end
    end
    pick = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_n = state;
    pwm_n   = pwm;
    wrap    = (cnt == last_cnt);
    cnt_n   = wrap ? '0 : cnt + 1'b1;

    if (cnt_n == blank_cnt) begin
      state_n = ST_ON;
    end else if (wrap) begin
      state_n = ST_BLANK;
    end

    unique case (state)
      ST_ON:    pwm_n = pwm + 1'b1;
      ST_BLANK: pwm_n = pwm;
      default:  pwm_n = pwm;
    endcase

    boundary = wrap && (!lo_found || pick <= idx);
    idx_n    = (wrap && lo_found) ? pick : idx;
    valid_n  = wrap ? lo_found : valid;

    commit    = boundary && pending;
    take      = bus.load && !pending;
    active_n  = commit ? shadow : active;
    shadow_n  = take ? bus.frame : shadow;
    pending_n = take || (pending && !commit);

    lit = (state_n == ST_ON) && valid_n &&
          ((bus.brightness == '1) || (pwm_n < bus.brightness));

    seg_n = '0;
    dig_n = '0;
    if (lit) begin
      seg_n = active_n[8*int'(idx_n) +: 8];
      dig_n = dig_t'(1) << idx_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_BLANK;
      cnt     <= '0;
      idx     <= '0;
      valid   <= 1'b1;
      pwm     <= '0;
      pending <= 1'b0;
      shadow  <= '0;
      active  <= '0;
      seg_q   <= '0;
      dig_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      valid   <= valid_n;
      pwm     <= pwm_n;
      pending <= pending_n;
      shadow  <= shadow_n;
      active  <= active_n;
      seg_q   <= seg_n;
      dig_q   <= dig_n;
      ready_q <= !pending_n;
      done_q  <= boundary;
    end
  end

  assign bus.abcdefgh   = seg_q;
  assign bus.digit      = dig_q;
  assign bus.ready      = ready_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Randomised bench for the scan controller against a slot/phase-level
// model, with literal checks pinning reset, scan order and PWM duty.
module tb_seven_segment_scan_controller;

  localparam int nd = 4;
  localparam int sc = 20;
  localparam int bc = 4;
  localparam int wb = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seven_segment_scan_controller_if #(.w_digit(nd), .w_bright(wb)) bus();

  seven_segment_scan_controller #(
    .clk_mhz(50),
    .w_digit(nd),
    .slot_cycles(sc),
    .blank_cycles(bc),
    .w_bright(wb)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: absolute slot phase, scanned index, count of ON cycles.
  int          ph;
  int          m_idx;
  int          m_ons;
  bit          m_valid;
  bit          m_pend;
  logic [31:0] m_shadow;
  logic [31:0] m_active;
  logic [7:0]  e_seg;
  logic [3:0]  e_dig;
  logic        e_ready;
  logic        e_done;

  always @(posedge clk) begin : model
    int nidx;
    bit any;
    bit found;
    bit bnd;
    bit take;
    bit lit;
    if (!rst) begin
      ph = 0;
      m_idx = 0;
      m_ons = 0;
      m_valid = 1'b1;
      m_pend = 1'b0;
      m_shadow = '0;
      m_active = '0;
      e_seg = '0;
      e_dig = '0;
      e_ready = 1'b1;
      e_done = 1'b0;
    end else begin
      take = bus.load && !m_pend;
      if (ph >= bc) m_ons++;
      bnd = 1'b0;
      if (ph == sc - 1) begin
        any = (bus.enable_mask != 0);
        nidx = m_idx;
        found = 1'b0;
        for (int j = 1; j <= nd; j++) begin
          if (!found && bus.enable_mask[(m_idx + j) % nd]) begin
            found = 1'b1;
            nidx = (m_idx + j) % nd;
          end
        end
        bnd = !any || (nidx <= m_idx);
        m_idx = nidx;
        m_valid = any;
      end
      if (bnd && m_pend) begin
        m_active = m_shadow;
        m_pend = 1'b0;
      end
      if (take) begin
        m_shadow = bus.frame;
        m_pend = 1'b1;
      end
      ph = (ph + 1) % sc;
      lit = (ph >= bc) && m_valid &&
            (bus.brightness == 3 || (m_ons % 4) < bus.brightness);
      e_done = bnd;
      e_ready = !m_pend;
      e_dig = lit ? 4'(1 << m_idx) : 4'd0;
      e_seg = lit ? m_active[8*m_idx +: 8] : 8'd0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("digit", 32'(bus.digit), 32'(e_dig));
      chk("abcdefgh", 32'(bus.abcdefgh), 32'(e_seg));
      chk("ready", 32'(bus.ready), 32'(e_ready));
      chk("frame_done", 32'(bus.frame_done), 32'(e_done));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (bus.frame_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk("wait_done", 32'(bus.frame_done), 32'd1);
  endtask

  task automatic period(output int p);
    int a;
    int b;
    wait_done(200, a);
    tick();
    wait_done(200, b);
    p = b + 1;
  endtask

  task automatic count_lit(input int n, output int c);
    c = 0;
    repeat (n) begin
      tick();
      if (bus.digit != 0) c++;
    end
  endtask

  task automatic load_frame(input logic [31:0] f);
    bus.frame = f;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int p;
    int c;
    bus.load = 1'b0;
    bus.frame = '0;
    bus.enable_mask = 4'hf;
    bus.brightness = 2'd3;
    rst = 1'b0;
    tick();
    chk_en = 1'b1;
    tick(2);
    chk("rst_digit", 32'(bus.digit), 32'd0);
    chk("rst_seg", 32'(bus.abcdefgh), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    chk("rst_done", 32'(bus.frame_done), 32'd0);

    rst = 1'b1;
    chk("c0_dark", 32'(bus.digit), 32'd0);
    for (int k = 1; k < bc; k++) begin
      tick();
      chk("blank_dark", 32'(bus.digit), 32'd0);
    end
    tick();
    chk("first_on", 32'(bus.digit), 32'd1);

    load_frame(32'h8040_2010);
    chk("ready_low", 32'(bus.ready), 32'd0);
    wait_done(100, n);
    chk("ready_at_done", 32'(bus.ready), 32'd1);
    tick(4);
    chk("scan0_dig", 32'(bus.digit), 32'h1);
    chk("scan0_seg", 32'(bus.abcdefgh), 32'h10);
    tick(20);
    chk("scan1_dig", 32'(bus.digit), 32'h2);
    chk("scan1_seg", 32'(bus.abcdefgh), 32'h20);
    tick(20);
    chk("scan2_dig", 32'(bus.digit), 32'h4);
    chk("scan2_seg", 32'(bus.abcdefgh), 32'h40);
    tick(20);
    chk("scan3_dig", 32'(bus.digit), 32'h8);
    chk("scan3_seg", 32'(bus.abcdefgh), 32'h80);
    period(p);
    chk("period_1111", 32'(p), 32'd80);

    bus.enable_mask = 4'b1010;
    period(p);
    period(p);
    chk("period_1010", 32'(p), 32'd40);
    bus.enable_mask = 4'b0100;
    period(p);
    period(p);
    chk("period_0100", 32'(p), 32'd20);

    bus.enable_mask = 4'hf;
    period(p);
    load_frame(32'h0102_0304);
    load_frame(32'haabb_ccdd);
    wait_done(100, n);
    chk("notear_ready", 32'(bus.ready), 32'd1);
    tick(4);
    chk("notear_seg", 32'(bus.abcdefgh), 32'h04);

    bus.brightness = 2'd1;
    tick(2);
    count_lit(20, c);
    chk("bright1", 32'(c), 32'd4);
    bus.brightness = 2'd0;
    tick(2);
    count_lit(20, c);
    chk("bright0", 32'(c), 32'd0);
    bus.brightness = 2'd3;
    tick(2);
    count_lit(20, c);
    chk("bright3", 32'(c), 32'd16);

    bus.enable_mask = 4'b0000;
    load_frame(32'h1111_2222);
    wait_done(40, n);
    chk("mask0_commit", 32'(bus.ready), 32'd1);
    count_lit(40, c);
    chk("mask0_dark", 32'(c), 32'd0);

    repeat (600) begin
      bus.load = ($urandom_range(0, 7) == 0);
      bus.frame = $urandom;
      if ($urandom_range(0, 29) == 0) bus.enable_mask = 4'($urandom);
      if ($urandom_range(0, 9) == 0) bus.brightness = 2'($urandom);
      rst = ($urandom_range(0, 199) != 0);
      tick();
    end
    bus.load = 1'b0;
    rst = 1'b1;
    bus.enable_mask = 4'hf;
    bus.brightness = 2'd3;

    wait_done(200, n);
    n = 0;
    while (bus.digit !== 4'b0100 && n < 100) begin
      tick();
      n++;
    end
    chk("reach_digit2", 32'(bus.digit), 32'h4);
    load_frame(32'hffff_ffff);
    chk("mid_pending", 32'(bus.ready), 32'd0);
    rst = 1'b0;
    tick();
    chk("mid_rst_digit", 32'(bus.digit), 32'd0);
    chk("mid_rst_seg", 32'(bus.abcdefgh), 32'd0);
    chk("mid_rst_ready", 32'(bus.ready), 32'd1);
    chk("mid_rst_done", 32'(bus.frame_done), 32'd0);
    rst = 1'b1;
    c = 0;
    repeat (100) begin
      tick();
      if (bus.abcdefgh != 0) c++;
    end
    chk("pending_lost", 32'(c), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
